// File: rtl/cpsr_flag_ctrl.sv
`default_nettype none
// ============================================================================
// cpsr_flag_ctrl : NZCV flag-write arbiter, CPSR initialiser and ARM
//                  condition evaluator with stall/forward across CPSR latency
// Revision: 1.0
// ============================================================================
module cpsr_flag_ctrl #(
  parameter logic FORWARD = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_req,
  input  logic [3:0] alu_flags,
  input  logic [3:0] alu_mask,
  output logic       alu_gnt,
  input  logic       sys_req,
  input  logic [3:0] sys_flags,
  output logic       sys_gnt,
  input  logic       cond_valid,
  input  logic [3:0] cond,
  output logic       cond_pass,
  output logic       stall,
  output logic       ready,
  output logic [3:0] cpsr_datain,
  output logic       cpsr_we,
  input  logic [3:0] cpsr_dataout
);

  localparam logic [1:0] c_ST_INIT      = 2'd0;
  localparam logic [1:0] c_ST_INIT_WAIT = 2'd1;
  localparam logic [1:0] c_ST_RUN       = 2'd2;

  logic [1:0] r_state;
  logic [3:0] r_flags_q;
  logic       r_pending;
  logic       r_cpsr_we;
  logic [3:0] r_cpsr_datain;

  logic       w_run;
  logic       w_hazard;
  logic       w_grant;
  logic [3:0] w_src;
  logic [3:0] w_merged;
  logic [3:0] w_new;
  logic       w_eval;
  logic       w_n;
  logic       w_z;
  logic       w_c;
  logic       w_v;

  // Gating with rst_n keeps grants and passes low while reset is held.
  assign w_run    = rst_n && (r_state == c_ST_RUN);
  assign w_hazard = !FORWARD && cond_valid && r_pending;

  assign sys_gnt  = w_run && !w_hazard && sys_req;
  assign alu_gnt  = w_run && !w_hazard && alu_req && !sys_req;
  assign w_grant  = sys_gnt || alu_gnt;

  assign w_merged = (alu_flags & alu_mask) | (r_flags_q & ~alu_mask);
  assign w_new    = sys_gnt ? sys_flags : w_merged;

  assign w_src = FORWARD ? r_flags_q : cpsr_dataout;
  assign w_n   = w_src[3];
  assign w_z   = w_src[2];
  assign w_c   = w_src[1];
  assign w_v   = w_src[0];

  always_comb begin
    w_eval = 1'b0;
    case (cond)
      4'b0000: w_eval = w_z;
      4'b0001: w_eval = !w_z;
      4'b0010: w_eval = w_c;
      4'b0011: w_eval = !w_c;
      4'b0100: w_eval = w_n;
      4'b0101: w_eval = !w_n;
      4'b0110: w_eval = w_v;
      4'b0111: w_eval = !w_v;
      4'b1000: w_eval = w_c && !w_z;
      4'b1001: w_eval = !w_c || w_z;
      4'b1010: w_eval = (w_n == w_v);
      4'b1011: w_eval = (w_n != w_v);
      4'b1100: w_eval = !w_z && (w_n == w_v);
      4'b1101: w_eval = w_z || (w_n != w_v);
      4'b1110: w_eval = 1'b1;
      default: w_eval = 1'b0;
    endcase
  end

  assign cond_pass   = w_run && cond_valid && !w_hazard && w_eval;
  assign stall       = !w_run || w_hazard;
  assign ready       = w_run;
  assign cpsr_we     = r_cpsr_we;
  assign cpsr_datain = r_cpsr_datain;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= c_ST_INIT;
      r_flags_q     <= 4'b0000;
      r_pending     <= 1'b0;
      r_cpsr_we     <= 1'b0;
      r_cpsr_datain <= 4'b0000;
    end else begin
      r_cpsr_we <= 1'b0;
      r_pending <= 1'b0;
      case (r_state)
        c_ST_INIT: begin
          // CPSR storage has no reset, so clear it through its write port.
          r_cpsr_we     <= 1'b1;
          r_cpsr_datain <= 4'b0000;
          r_flags_q     <= 4'b0000;
          r_state       <= c_ST_INIT_WAIT;
        end
        c_ST_INIT_WAIT: begin
          r_state <= c_ST_RUN;
        end
        c_ST_RUN: begin
          if (w_grant) begin
            r_flags_q     <= w_new;
            r_cpsr_datain <= w_new;
            r_cpsr_we     <= 1'b1;
            r_pending     <= 1'b1;
          end
        end
        default: begin
          r_state <= c_ST_INIT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpsr_flag_ctrl.sv
`default_nettype none
// ============================================================================
// tb_cpsr_flag_ctrl : directed bench driving a FORWARD=0 and a FORWARD=1
//                     instance from shared stimulus, each with a CPSR model
// Revision: 1.0
// ============================================================================
module tb_cpsr_flag_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alu_req;
  logic [3:0] alu_flags;
  logic [3:0] alu_mask;
  logic       sys_req;
  logic [3:0] sys_flags;
  logic       cond_valid;
  logic [3:0] cond;

  logic       alu_gnt0, sys_gnt0, cond_pass0, stall0, ready0, we0;
  logic [3:0] din0, mem0;
  logic       alu_gnt1, sys_gnt1, cond_pass1, stall1, ready1, we1;
  logic [3:0] din1, mem1;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // CPSR storage models: one-cycle write, no reset
  always @(posedge clk) if (we0) mem0 <= din0;
  always @(posedge clk) if (we1) mem1 <= din1;

  cpsr_flag_ctrl #(.FORWARD(1'b0)) u_fwd0 (
    .clk(clk), .rst_n(rst_n),
    .alu_req(alu_req), .alu_flags(alu_flags), .alu_mask(alu_mask), .alu_gnt(alu_gnt0),
    .sys_req(sys_req), .sys_flags(sys_flags), .sys_gnt(sys_gnt0),
    .cond_valid(cond_valid), .cond(cond), .cond_pass(cond_pass0),
    .stall(stall0), .ready(ready0),
    .cpsr_datain(din0), .cpsr_we(we0), .cpsr_dataout(mem0)
  );

  cpsr_flag_ctrl #(.FORWARD(1'b1)) u_fwd1 (
    .clk(clk), .rst_n(rst_n),
    .alu_req(alu_req), .alu_flags(alu_flags), .alu_mask(alu_mask), .alu_gnt(alu_gnt1),
    .sys_req(sys_req), .sys_flags(sys_flags), .sys_gnt(sys_gnt1),
    .cond_valid(cond_valid), .cond(cond), .cond_pass(cond_pass1),
    .stall(stall1), .ready(ready1),
    .cpsr_datain(din1), .cpsr_we(we1), .cpsr_dataout(mem1)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Pass bitmaps indexed by cond, hand-derived from the condition table.
  logic [3:0]  fl [4];
  logic [15:0] pm [4];

  initial begin
    fl[0] = 4'b0000; pm[0] = 16'h56AA;
    fl[1] = 4'b1001; pm[1] = 16'h565A;
    fl[2] = 4'b0110; pm[2] = 16'h66A5;
    fl[3] = 4'b1111; pm[3] = 16'h6655;

    rst_n = 1'b0; alu_req = 1'b1; alu_flags = 4'b1111; alu_mask = 4'b1111;
    sys_req = 1'b1; sys_flags = 4'b1111; cond_valid = 1'b1; cond = 4'b1110;

    nxt(); nxt(); #2;
    chk("rst_ready0", {3'b0, ready0}, 4'd0);
    chk("rst_stall0", {3'b0, stall0}, 4'd1);
    chk("rst_gnt0",   {2'b0, alu_gnt0, sys_gnt0}, 4'd0);
    chk("rst_gnt1",   {2'b0, alu_gnt1, sys_gnt1}, 4'd0);
    chk("rst_pass1",  {3'b0, cond_pass1}, 4'd0);
    chk("rst_stall1", {3'b0, stall1}, 4'd1);
    chk("rst_we0",    {3'b0, we0}, 4'd0);
    chk("rst_din0",   din0, 4'b0000);

    // c0
    nxt(); rst_n = 1'b1; alu_req = 1'b0; sys_req = 1'b0; cond_valid = 1'b0; #2;
    chk("c0_ready0", {3'b0, ready0}, 4'd0);
    chk("c0_we0",    {3'b0, we0}, 4'd0);
    // c1
    nxt(); #2;
    chk("c1_we0",    {3'b0, we0}, 4'd1);
    chk("c1_din0",   din0, 4'b0000);
    chk("c1_we1",    {3'b0, we1}, 4'd1);
    chk("c1_ready1", {3'b0, ready1}, 4'd0);
    // c2
    nxt(); cond_valid = 1'b1; cond = 4'b0000; #2;
    chk("c2_ready0", {3'b0, ready0}, 4'd1);
    chk("c2_ready1", {3'b0, ready1}, 4'd1);
    chk("c2_dout0",  mem0, 4'b0000);
    chk("c2_eq0",    {3'b0, cond_pass0}, 4'd0);
    chk("c2_eq1",    {3'b0, cond_pass1}, 4'd0);
    chk("c2_stall0", {3'b0, stall0}, 4'd0);

    // masked merge
    nxt(); cond_valid = 1'b0; sys_req = 1'b1; sys_flags = 4'b1111; #2;
    chk("mm_sysgnt0", {3'b0, sys_gnt0}, 4'd1);
    chk("mm_sysgnt1", {3'b0, sys_gnt1}, 4'd1);
    nxt(); sys_req = 1'b0; alu_req = 1'b1; alu_flags = 4'b0000; alu_mask = 4'b1100; #2;
    chk("mm_alugnt0", {3'b0, alu_gnt0}, 4'd1);
    chk("mm_din_sys", din0, 4'b1111);
    nxt(); alu_req = 1'b0; #2;
    chk("mm_din0",  din0, 4'b0011);
    chk("mm_din1",  din1, 4'b0011);
    chk("mm_we0",   {3'b0, we0}, 4'd1);
    chk("mm_dold0", mem0, 4'b1111);
    nxt(); cond_valid = 1'b1; cond = 4'b0001; #2;
    chk("mm_dout0", mem0, 4'b0011);
    chk("mm_ne0",   {3'b0, cond_pass0}, 4'd1);
    chk("mm_ne1",   {3'b0, cond_pass1}, 4'd1);
    nxt(); cond = 4'b0010; #2;
    chk("mm_cs0",   {3'b0, cond_pass0}, 4'd1);
    chk("mm_cs1",   {3'b0, cond_pass1}, 4'd1);

    // conflict: system wins, ALU merges over the system value next cycle
    nxt(); cond_valid = 1'b0; alu_req = 1'b1; alu_flags = 4'b1011; alu_mask = 4'b0011;
    sys_req = 1'b1; sys_flags = 4'b0100; #2;
    chk("cf_sysgnt0", {3'b0, sys_gnt0}, 4'd1);
    chk("cf_alugnt0", {3'b0, alu_gnt0}, 4'd0);
    chk("cf_alugnt1", {3'b0, alu_gnt1}, 4'd0);
    nxt(); sys_req = 1'b0; #2;
    chk("cf_alugnt0b", {3'b0, alu_gnt0}, 4'd1);
    chk("cf_din0",     din0, 4'b0100);
    nxt(); alu_req = 1'b0; #2;
    chk("cf_din0b", din0, 4'b0111);
    chk("cf_din1b", din1, 4'b0111);
    nxt(); #2;
    chk("cf_dout0", mem0, 4'b0111);

    // hazard / forwarding on a Z 0->1 write
    nxt(); sys_req = 1'b1; sys_flags = 4'b0000; #2;
    nxt(); sys_req = 1'b0; #2;
    nxt(); alu_req = 1'b1; alu_flags = 4'b0100; alu_mask = 4'b0100;
    cond_valid = 1'b1; cond = 4'b0000; #2;
    chk("hz_t_gnt0",  {3'b0, alu_gnt0}, 4'd1);
    chk("hz_t_eq0",   {3'b0, cond_pass0}, 4'd0);
    chk("hz_t_eq1",   {3'b0, cond_pass1}, 4'd0);
    chk("hz_t_stl0",  {3'b0, stall0}, 4'd0);
    nxt(); alu_mask = 4'b0000; #2;
    chk("hz_t1_stl0", {3'b0, stall0}, 4'd1);
    chk("hz_t1_gnt0", {3'b0, alu_gnt0}, 4'd0);
    chk("hz_t1_eq0",  {3'b0, cond_pass0}, 4'd0);
    chk("hz_t1_stl1", {3'b0, stall1}, 4'd0);
    chk("hz_t1_eq1",  {3'b0, cond_pass1}, 4'd1);
    nxt(); alu_req = 1'b0; #2;
    chk("hz_t2_stl0", {3'b0, stall0}, 4'd0);
    chk("hz_t2_eq0",  {3'b0, cond_pass0}, 4'd1);
    chk("hz_t2_eq1",  {3'b0, cond_pass1}, 4'd1);

    // condition sweep
    for (int f = 0; f < 4; f++) begin
      nxt(); cond_valid = 1'b0; sys_req = 1'b1; sys_flags = fl[f]; #2;
      chk("sw_sysgnt0", {3'b0, sys_gnt0}, 4'd1);
      nxt(); sys_req = 1'b0;
      for (int k = 0; k < 16; k++) begin
        nxt(); cond_valid = 1'b1; cond = 4'(k); #2;
        chk($sformatf("sw_f%0d_c%0d_fwd0", f, k), {3'b0, cond_pass0}, {3'b0, pm[f][k]});
        chk($sformatf("sw_f%0d_c%0d_fwd1", f, k), {3'b0, cond_pass1}, {3'b0, pm[f][k]});
      end
      chk("sw_stall0", {3'b0, stall0}, 4'd0);
    end

    // reset abort after a grant
    nxt(); cond_valid = 1'b0; alu_req = 1'b1; alu_flags = 4'b1010; alu_mask = 4'b1111; #2;
    chk("ra_gnt0", {3'b0, alu_gnt0}, 4'd1);
    nxt(); rst_n = 1'b0; #2;
    chk("ra_rgnt0",  {3'b0, alu_gnt0}, 4'd0);
    chk("ra_rgnt1",  {3'b0, alu_gnt1}, 4'd0);
    chk("ra_ready0", {3'b0, ready0}, 4'd0);
    chk("ra_stall1", {3'b0, stall1}, 4'd1);
    nxt(); rst_n = 1'b1; alu_req = 1'b0; #2;
    chk("ra_c0_we0", {3'b0, we0}, 4'd0);
    chk("ra_c0_we1", {3'b0, we1}, 4'd0);
    chk("ra_c0_rdy", {3'b0, ready1}, 4'd0);
    nxt(); #2;
    chk("ra_c1_we0",  {3'b0, we0}, 4'd1);
    chk("ra_c1_din0", din0, 4'b0000);
    nxt(); cond_valid = 1'b1; cond = 4'b0001; #2;
    chk("ra_c2_rdy0", {3'b0, ready0}, 4'd1);
    chk("ra_c2_dout", mem0, 4'b0000);
    chk("ra_c2_ne0",  {3'b0, cond_pass0}, 4'd1);
    chk("ra_c2_ne1",  {3'b0, cond_pass1}, 4'd1);
    nxt(); cond = 4'b0000; #2;
    chk("ra_c3_eq0",  {3'b0, cond_pass0}, 4'd0);
    chk("ra_c3_eq1",  {3'b0, cond_pass1}, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
